// File: rtl/pipe_sel2_pkg.sv
// Shared pipeline constants for the pipe_sel2 word selector.
package pipe_sel2_pkg;

   localparam int DATA_W = 32;

   localparam logic SEL_LSB = 1'b0;
   localparam logic SEL_MSB = 1'b1;

endpackage : pipe_sel2_pkg

// File: rtl/pipe_sel2_dff_rst.sv
// dff_rst: nbits-wide register with synchronous active-high reset to zero.
module dff_rst
   import pipe_sel2_pkg::*;
#(
   parameter int nbits = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [nbits-1:0] d,
   output logic [nbits-1:0] q
);

   // Data register, cleared on a sampled reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= {nbits{1'b0}};
      end else begin
         q <= d;
      end
   end

endmodule : dff_rst

// File: rtl/pipe_sel2.sv
// pipe_sel2: 2-to-1 word selector with a registered select-change pulse.
// Build option MUX_OUT_REG_EN registers the selected word (1-cycle latency).
module pipe_sel2
   import pipe_sel2_pkg::*;
#(
   parameter int nbits = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [nbits-1:0] msb,
   input  logic [nbits-1:0] lsb,
   input  logic             dec,
   output logic [nbits-1:0] out,
   output logic             switched
);

   logic [nbits-1:0] sel_s;
   logic             dec_q_r;
   logic             dec_q_prev_r;
   logic             switch_s;

   // Conditional operator keeps X-merge behaviour when dec is not binary.
   assign sel_s = (dec == SEL_MSB) ? msb : lsb;

`ifdef MUX_OUT_REG_EN
   dff_rst #(.nbits(nbits)) u_out_reg (
      .clk   (clk),
      .reset (reset),
      .d     (sel_s),
      .q     (out)
   );
`else
   assign out = sel_s;
`endif

   dff_rst #(.nbits(1)) u_dec_q (
      .clk   (clk),
      .reset (reset),
      .d     (dec),
      .q     (dec_q_r)
   );

   dff_rst #(.nbits(1)) u_dec_q_prev (
      .clk   (clk),
      .reset (reset),
      .d     (dec_q_r),
      .q     (dec_q_prev_r)
   );

   // A change seen between the two tracking stages is registered once more.
   assign switch_s = dec_q_prev_r ^ dec_q_r;

   dff_rst #(.nbits(1)) u_switched (
      .clk   (clk),
      .reset (reset),
      .d     (switch_s),
      .q     (switched)
   );

endmodule : pipe_sel2

// File: tb/tb_pipe_sel2.sv
// Directed self-checking bench for pipe_sel2 at nbits = 3.
module tb_pipe_sel2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] msb = 3'd0;
   logic [2:0] lsb = 3'd0;
   logic       dec = 1'b0;
   logic [2:0] out;
   logic       switched;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_sel2 #(.nbits(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .msb      (msb),
      .lsb      (lsb),
      .dec      (dec),
      .out      (out),
      .switched (switched)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_sw(input string name, input logic exp);
      n_tests++;
      if (switched !== exp) begin
         n_fail++;
         $display("FAIL %s: switched=%b expected=%b", name, switched, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [2:0] exp);
      n_tests++;
      if (out !== exp) begin
         n_fail++;
         $display("FAIL %s: out=%0d expected=%0d", name, out, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; dec = 1'b0; msb = 3'd3; lsb = 3'd0;
      tick();
      tick();
      chk_sw("reset_switched", 1'b0);
`ifdef MUX_OUT_REG_EN
      chk_out("reset_out", 3'd0);
`endif
      reset = 1'b0;
      tick();
      chk_sw("reset_release_dec0", 1'b0);
   endtask

`ifdef MUX_OUT_REG_EN
   task automatic test_out_reg();
      reset = 1'b1; msb = 3'd3; lsb = 3'd0; dec = 1'b0;
      tick();
      chk_out("oreg_reset_dec0", 3'd0);
      dec = 1'b1;
      tick();
      chk_out("oreg_reset_dec1", 3'd0);
      reset = 1'b0; dec = 1'b0;
      tick();
      chk_out("oreg_lsb", 3'd0);
      dec = 1'b1;
      #1;
      chk_out("oreg_not_before_edge", 3'd0);
      tick();
      chk_out("oreg_after_edge", 3'd3);
      msb = 3'd6;
      #1;
      chk_out("oreg_hold", 3'd3);
      tick();
      chk_out("oreg_msb_update", 3'd6);
   endtask
`else
   task automatic test_comb_select();
      msb = 3'd3; lsb = 3'd0;
      dec = 1'b0; #1; chk_out("comb_dec0_a", 3'd0);
      dec = 1'b1; #1; chk_out("comb_dec1_a", 3'd3);
      dec = 1'b0; #1; chk_out("comb_dec0_b", 3'd0);
      dec = 1'b1; #1; chk_out("comb_dec1_b", 3'd3);
   endtask

   task automatic test_full_width();
      msb = 3'd7; lsb = 3'd5;
      dec = 1'b1; #1; chk_out("width_msb_a", 3'd7);
      dec = 1'b0; #1; chk_out("width_lsb_a", 3'd5);
      dec = 1'b1; #1; chk_out("width_msb_b", 3'd7);
      msb = 3'd2; lsb = 3'd4;
      #1; chk_out("width_msb_c", 3'd2);
      dec = 1'b0; #1; chk_out("width_lsb_c", 3'd4);
   endtask

   task automatic test_input_change();
      dec = 1'b1; msb = 3'd3; lsb = 3'd1;
      #1; chk_out("inchg_msb3", 3'd3);
      msb = 3'd6;
      #1; chk_out("inchg_msb6", 3'd6);
      lsb = 3'd5;
      #1; chk_out("inchg_lsb_ignored", 3'd6);
   endtask
`endif

   task automatic test_switch_pulse();
      reset = 1'b1; dec = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_sw("pulse_idle", 1'b0);
      end
      dec = 1'b1;
      tick();
      chk_sw("pulse_edge_n", 1'b0);
      tick();
      chk_sw("pulse_edge_n1", 1'b1);
      tick();
      chk_sw("pulse_edge_n2", 1'b0);
      tick();
      chk_sw("pulse_edge_n3", 1'b0);
   endtask

   task automatic test_toggle();
      reset = 1'b1; dec = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dec = ~dec;
         tick();
         if (i >= 1) chk_sw("toggle_continuous", 1'b1);
      end
      tick();
      chk_sw("toggle_last_change", 1'b1);
      tick();
      chk_sw("toggle_settled", 1'b0);
   endtask

   task automatic test_reset_priority();
      reset = 1'b1; dec = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk_sw("prio_idle", 1'b0);
      dec = 1'b1; reset = 1'b1;
      tick();
      chk_sw("prio_same_edge", 1'b0);
      reset = 1'b0;
      tick();
      chk_sw("prio_release_r1", 1'b0);
      tick();
      chk_sw("prio_release_r2", 1'b1);
      tick();
      tick();
      chk_sw("prio_settled", 1'b0);
      dec = 1'b0;
      tick();
      chk_sw("pending_edge_n", 1'b0);
      reset = 1'b1;
      tick();
      chk_sw("pending_discard", 1'b0);
      reset = 1'b0;
      tick();
      chk_sw("pending_after_a", 1'b0);
      tick();
      chk_sw("pending_after_b", 1'b0);
   endtask

   initial begin
      test_reset();
`ifdef MUX_OUT_REG_EN
      test_out_reg();
`else
      test_comb_select();
      test_full_width();
      test_input_change();
`endif
      test_switch_pulse();
      test_toggle();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule : tb_pipe_sel2
